gesture_pio_in: RTL and testbench
=================================

# gesture_pio_in

Parametrised Avalon-MM input PIO with synchronisation, per-bit debounce, edge capture and a maskable interrupt. It replaces the single-bit, poll-only input PIO for the gesture and button inputs of the snake game. Nios II software can then take an interrupt on a debounced rising, falling or any edge instead of polling. Register map: data at 0, mask at 2, edge-capture at 3.

## Interface
- WIDTH, 4: number of input bits and width of readdata and writedata (1..32).
- EDGE_TYPE, 0: edge that sets a capture bit. 0 = rising, 1 = falling, 2 = any.
- DEBOUNCE_CYCLES, 0: consecutive stable cycles required before the debounced value changes. 0 bypasses debounce.
- SYNC_STAGES, 2: synchroniser flops per bit (>=2).

- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  2  Avalon word address.
- chipselect  in  1  slave select. Gates writes only.
- write_n  in  1  active-low write strobe.
- writedata  in  WIDTH  write data.
- in_port  in  WIDTH  asynchronous external inputs.
- readdata  out  WIDTH  registered read data.
- irq  out  1  level interrupt, active high.

## Operation
- **Reset:** all flops clear to 0. This includes sync stages, debounce counters, stable value, previous value, irq_mask, edge_capture and readdata. irq = 0.
- **Synchroniser:** each bit of in_port passes through SYNC_STAGES flops. The last stage output is s.
- **Debounce, DEBOUNCE_CYCLES = 0:** stable = s, combinationally.
- **Debounce, DEBOUNCE_CYCLES = D >= 1:** each bit has a counter of clog2(D+1) bits.
  - s == stable: counter <= 0.
  - s != stable and counter == D-1: stable <= s, counter <= 0.
  - Otherwise: counter <= counter + 1.
  - Any glitch shorter than D cycles leaves stable unchanged.
- **Edge detect:** prev <= stable every cycle.
  - Rising = stable & ~prev.
  - Falling = ~stable & prev.
  - Any = stable ^ prev.
  - The selected edge vector is ev.
- **Edge capture:** edge_capture[i] <= (edge_capture[i] & ~clr[i]) | ev[i].
  - clr = writedata when chipselect & ~write_n & address == 3, otherwise 0.
  - If set and clear hit the same bit in the same cycle, set wins.
- **Mask register:** on chipselect & ~write_n & address == 2, irq_mask <= writedata.
- **Ignored writes:** writes to addresses 0 and 1 have no effect.
- **Read mux:** updated every cycle, with no chipselect dependency.
  - address 0: stable.
  - address 1: 0 (reserved).
  - address 2: irq_mask.
  - address 3: edge_capture.
- **Interrupt:** irq = |(edge_capture & irq_mask). It is combinational from registers and glitch-free.
- **Idle-high inputs at reset release:** these produce a rising edge after synchronisation, because the sync stages reset to 0. With EDGE_TYPE = 0 or 2, software must clear edge_capture after enabling.

## Timing
- **Read latency:** 1 cycle. readdata at edge k+1 reflects the address and register contents present at edge k.
- **Input to stable, all D:** in_port changes before edge 1 (SYNC_STAGES = 2). Stable updates at edge 2+D. For D = 0, stable follows s from edge 2.
- **Edge capture:** the capture bit sets at edge 3+D.
- **irq:** asserts after edge 3+D if the mask bit is set. It deasserts the cycle after a clearing write or a mask write that removes the last enabled bit.
- **Data read:** readdata for address 0 shows the new value from edge 3+D.
- **Mask write:** takes effect on irq immediately after the write edge.
- **Asynchronous reset mid-operation:** all state, including partial debounce counts, clears at once. irq drops without waiting for a clock.

## Test plan
- **Reset:** hold reset_n = 0 with in_port = 4'hF and toggle clk. Response: readdata = 0 and irq = 0 throughout. After release, with address 0 and D = 0, readdata = 4'hF at edge 3.
- **Rising capture and irq (D = 0, EDGE_TYPE = 0):**
  - Stimulus: write mask 4'h1, then clear capture 4'hF. Drive in_port[0] 0→1.
  - Response: capture reads 4'h1 and irq = 1 from edge 3.
  - Write 4'h1 to address 3. Response: irq = 0 the next cycle and capture reads 0.
- **Debounce (D = 4):**
  - A 3-cycle pulse on in_port[1] leaves stable[1] = 0 and capture = 0.
  - A 4-cycle hold sets stable[1] at edge 6 and capture[1] at edge 7.
- **Set/clear collision:** schedule a write of 4'h2 to address 3 on the same edge bit 1 captures an edge. Response: capture[1] = 1 after that edge.
- **Edge modes and masking:**
  - EDGE_TYPE = 1: a rising edge does not set capture. A falling edge does.
  - EDGE_TYPE = 2: both edges set capture.
  - Captured bit with mask = 0: irq stays 0.
  - Address 1 always reads 0.
- **Reset mid-debounce (D = 4):** assert reset_n after 2 stable-differing cycles. Response: counter and stable = 0. After release, a full 4-cycle hold is needed again before stable changes.

Source files
------------

// File: rtl/gesture_pio_in.sv
// Avalon-MM input PIO for the gesture/button inputs: synchroniser, per-bit debounce,
// edge capture and a maskable level interrupt (data @0, mask @2, edge capture @3).
module gesture_pio_in #(
    parameter int WIDTH           = 4,
    parameter int EDGE_TYPE       = 0,
    parameter int DEBOUNCE_CYCLES = 0,
    parameter int SYNC_STAGES     = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [WIDTH-1:0] writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] readdata,
    output logic             irq
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
    logic [WIDTH-1:0] w_s;
    logic [WIDTH-1:0] w_stable;
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] w_ev;
    logic [WIDTH-1:0] w_clr;
    logic [WIDTH-1:0] r_cap;
    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] r_readdata;
    logic             w_wr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], in_port};
        end
    end

    assign w_s = r_sync[SYNC_STAGES-1];

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_nodb
            assign w_stable = w_s;
        end else begin : g_db
            localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
            logic [WIDTH-1:0] r_stable;
            logic [CW-1:0]    r_cnt [WIDTH];

            // A bit only follows s after D consecutive cycles of disagreement; any
            // agreement in between restarts the count.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_stable <= '0;
                    for (int i = 0; i < WIDTH; i++) begin
                        r_cnt[i] <= '0;
                    end
                end else begin
                    for (int i = 0; i < WIDTH; i++) begin
                        if (w_s[i] == r_stable[i]) begin
                            r_cnt[i] <= '0;
                        end else if (r_cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                            r_stable[i] <= w_s[i];
                            r_cnt[i]    <= '0;
                        end else begin
                            r_cnt[i] <= r_cnt[i] + 1'b1;
                        end
                    end
                end
            end

            assign w_stable = r_stable;
        end
    endgenerate

    always_comb begin
        w_ev = w_stable & ~r_prev;
        case (EDGE_TYPE)
            1:       w_ev = ~w_stable & r_prev;
            2:       w_ev = w_stable ^ r_prev;
            default: w_ev = w_stable & ~r_prev;
        endcase
    end

    assign w_wr  = chipselect & ~write_n;
    assign w_clr = (w_wr && address == 2'd3) ? writedata : '0;

    // A new edge in the same cycle as a clearing write keeps its capture bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prev <= '0;
            r_cap  <= '0;
            r_mask <= '0;
        end else begin
            r_prev <= w_stable;
            r_cap  <= (r_cap & ~w_clr) | w_ev;
            if (w_wr && address == 2'd2) begin
                r_mask <= writedata;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_readdata <= '0;
        end else begin
            case (address)
                2'd0:    r_readdata <= w_stable;
                2'd1:    r_readdata <= '0;
                2'd2:    r_readdata <= r_mask;
                default: r_readdata <= r_cap;
            endcase
        end
    end

    assign readdata = r_readdata;
    assign irq      = |(r_cap & r_mask);

endmodule

// File: tb/tb_gesture_pio_in.sv
// Bench for gesture_pio_in: four parameter variants share one bus and input stimulus,
// each compared every cycle against a history-based behavioural model.
module tb_gesture_pio_in;

    localparam int NI = 4;

    logic       clk;
    logic       resetN;
    logic [1:0] address;
    logic       chipselect;
    logic       writeN;
    logic [3:0] writedata;
    logic [3:0] inPort;
    logic [3:0] rdArr [NI];
    logic       irqArr [NI];

    int nAsserts;
    int nFails;

    // Debounce length and edge type of each instance, in instance order.
    int dbLen  [NI] = '{0, 4, 0, 2};
    int edgeTy [NI] = '{0, 0, 1, 2};

    logic [3:0] mSync0  [NI];
    logic [3:0] mSync1  [NI];
    logic [3:0] mStable [NI];
    logic [3:0] mPrev   [NI];
    logic [3:0] mCap    [NI];
    logic [3:0] mMask   [NI];
    logic [3:0] mRd     [NI];
    logic [3:0] mHist   [NI][8];
    int         mHistN  [NI];

    gesture_pio_in #(.WIDTH(4), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(0), .SYNC_STAGES(2)) u0 (
        .clk(clk), .reset_n(resetN), .address(address), .chipselect(chipselect),
        .write_n(writeN), .writedata(writedata), .in_port(inPort),
        .readdata(rdArr[0]), .irq(irqArr[0]));

    gesture_pio_in #(.WIDTH(4), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(4), .SYNC_STAGES(2)) u1 (
        .clk(clk), .reset_n(resetN), .address(address), .chipselect(chipselect),
        .write_n(writeN), .writedata(writedata), .in_port(inPort),
        .readdata(rdArr[1]), .irq(irqArr[1]));

    gesture_pio_in #(.WIDTH(4), .EDGE_TYPE(1), .DEBOUNCE_CYCLES(0), .SYNC_STAGES(2)) u2 (
        .clk(clk), .reset_n(resetN), .address(address), .chipselect(chipselect),
        .write_n(writeN), .writedata(writedata), .in_port(inPort),
        .readdata(rdArr[2]), .irq(irqArr[2]));

    gesture_pio_in #(.WIDTH(4), .EDGE_TYPE(2), .DEBOUNCE_CYCLES(2), .SYNC_STAGES(2)) u3 (
        .clk(clk), .reset_n(resetN), .address(address), .chipselect(chipselect),
        .write_n(writeN), .writedata(writedata), .in_port(inPort),
        .readdata(rdArr[3]), .irq(irqArr[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic modelReset();
        for (int k = 0; k < NI; k++) begin
            mSync0[k]  = 4'h0;
            mSync1[k]  = 4'h0;
            mStable[k] = 4'h0;
            mPrev[k]   = 4'h0;
            mCap[k]    = 4'h0;
            mMask[k]   = 4'h0;
            mRd[k]     = 4'h0;
            mHistN[k]  = 0;
        end
    endtask

    // One clock edge of the model: the debounced value flips a bit once the last
    // D synchronised samples all disagree with it.
    task automatic modelStep();
        logic [3:0] s, st, ev, clr;
        logic       isWr, allDiff;
        isWr = chipselect && !writeN;
        clr  = (isWr && address == 2'd3) ? writedata : 4'h0;
        for (int k = 0; k < NI; k++) begin
            s  = mSync1[k];
            st = (dbLen[k] == 0) ? s : mStable[k];
            if (edgeTy[k] == 0)      ev = st & ~mPrev[k];
            else if (edgeTy[k] == 1) ev = ~st & mPrev[k];
            else                     ev = st ^ mPrev[k];
            if (address == 2'd0)      mRd[k] = st;
            else if (address == 2'd1) mRd[k] = 4'h0;
            else if (address == 2'd2) mRd[k] = mMask[k];
            else                      mRd[k] = mCap[k];
            mCap[k] = (mCap[k] & ~clr) | ev;
            if (isWr && address == 2'd2) mMask[k] = writedata;
            mPrev[k] = st;
            if (dbLen[k] > 0) begin
                if (mHistN[k] == dbLen[k]) begin
                    for (int j = 0; j < dbLen[k] - 1; j++) mHist[k][j] = mHist[k][j+1];
                end else begin
                    mHistN[k]++;
                end
                mHist[k][mHistN[k]-1] = s;
                if (mHistN[k] == dbLen[k]) begin
                    for (int b = 0; b < 4; b++) begin
                        allDiff = 1'b1;
                        for (int j = 0; j < dbLen[k]; j++) begin
                            if (mHist[k][j][b] == mStable[k][b]) allDiff = 1'b0;
                        end
                        if (allDiff) mStable[k][b] = ~mStable[k][b];
                    end
                end
            end
            mSync1[k] = mSync0[k];
            mSync0[k] = inPort;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFails++;
            $error("[TB] FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic checkAll();
        for (int k = 0; k < NI; k++) begin
            checkOutput($sformatf("rd%0d", k), rdArr[k], mRd[k]);
            checkOutput($sformatf("irq%0d", k), {3'b0, irqArr[k]}, {3'b0, |(mCap[k] & mMask[k])});
        end
    endtask

    task automatic tick();
        if (!resetN) modelReset();
        else         modelStep();
        @(posedge clk);
        #1;
        checkAll();
    endtask

    task automatic applyStimulus(input logic [3:0] inp, input logic [1:0] a,
                                 input logic doWrite, input logic [3:0] d);
        inPort     = inp;
        address    = a;
        chipselect = doWrite;
        writeN     = ~doWrite;
        writedata  = d;
    endtask

    task automatic asyncReset();
        resetN = 1'b0;
        #1;
        modelReset();
        for (int k = 0; k < NI; k++) begin
            checkOutput($sformatf("asyncRd%0d", k), rdArr[k], 4'h0);
            checkOutput($sformatf("asyncIrq%0d", k), {3'b0, irqArr[k]}, 4'h0);
        end
        tick();
        tick();
        resetN = 1'b1;
    endtask

    initial begin
        nAsserts = 0;
        nFails   = 0;
        resetN   = 1'b0;
        applyStimulus(4'hF, 2'd0, 1'b0, 4'h0);
        modelReset();
        $display("[TB] reset with inputs high");
        repeat (3) tick();
        for (int k = 0; k < NI; k++) begin
            checkOutput($sformatf("rstRd%0d", k), rdArr[k], 4'h0);
            checkOutput($sformatf("rstIrq%0d", k), {3'b0, irqArr[k]}, 4'h0);
        end
        resetN = 1'b1;
        repeat (3) tick();
        checkOutput("releaseData", rdArr[0], 4'hF);

        $display("[TB] rising capture and irq");
        applyStimulus(4'h0, 2'd0, 1'b0, 4'h0);
        repeat (12) tick();
        applyStimulus(4'h0, 2'd2, 1'b1, 4'h1);
        tick();
        applyStimulus(4'h0, 2'd3, 1'b1, 4'hF);
        tick();
        applyStimulus(4'h1, 2'd3, 1'b0, 4'h0);
        tick();
        tick();
        checkOutput("irqBeforeEdge3", {3'b0, irqArr[0]}, 4'h0);
        tick();
        checkOutput("irqAtEdge3", {3'b0, irqArr[0]}, 4'h1);
        tick();
        checkOutput("capRead", rdArr[0], 4'h1);
        applyStimulus(4'h1, 2'd3, 1'b1, 4'h1);
        tick();
        checkOutput("irqCleared", {3'b0, irqArr[0]}, 4'h0);
        applyStimulus(4'h1, 2'd3, 1'b0, 4'h0);
        tick();
        checkOutput("capCleared", rdArr[0], 4'h0);

        $display("[TB] debounce glitch and hold");
        repeat (10) tick();
        applyStimulus(4'h1, 2'd3, 1'b1, 4'hF);
        tick();
        applyStimulus(4'h3, 2'd3, 1'b0, 4'h0);
        repeat (3) tick();
        applyStimulus(4'h1, 2'd3, 1'b0, 4'h0);
        repeat (10) tick();
        checkOutput("glitchCap", rdArr[1], 4'h0);
        applyStimulus(4'h3, 2'd0, 1'b0, 4'h0);
        repeat (6) tick();
        checkOutput("holdEdge6", rdArr[1], 4'h1);
        tick();
        checkOutput("holdEdge7", rdArr[1], 4'h3);
        applyStimulus(4'h3, 2'd3, 1'b0, 4'h0);
        tick();
        checkOutput("holdCap", rdArr[1], 4'h2);

        $display("[TB] set/clear collision");
        applyStimulus(4'h1, 2'd0, 1'b0, 4'h0);
        repeat (10) tick();
        applyStimulus(4'h1, 2'd3, 1'b1, 4'hF);
        tick();
        applyStimulus(4'h3, 2'd0, 1'b0, 4'h0);
        tick();
        tick();
        applyStimulus(4'h3, 2'd3, 1'b1, 4'h2);
        tick();
        applyStimulus(4'h3, 2'd3, 1'b0, 4'h0);
        tick();
        checkOutput("collisionCap", rdArr[0], 4'h2);

        $display("[TB] masking and reserved address");
        applyStimulus(4'h3, 2'd2, 1'b1, 4'h0);
        tick();
        applyStimulus(4'h3, 2'd3, 1'b1, 4'hF);
        tick();
        applyStimulus(4'h0, 2'd0, 1'b0, 4'h0);
        repeat (8) tick();
        applyStimulus(4'hF, 2'd0, 1'b0, 4'h0);
        repeat (8) tick();
        for (int k = 0; k < NI; k++) begin
            checkOutput($sformatf("maskedIrq%0d", k), {3'b0, irqArr[k]}, 4'h0);
        end
        applyStimulus(4'hF, 2'd1, 1'b1, 4'hF);
        tick();
        applyStimulus(4'hF, 2'd1, 1'b0, 4'h0);
        tick();
        for (int k = 0; k < NI; k++) begin
            checkOutput($sformatf("addr1Rd%0d", k), rdArr[k], 4'h0);
        end

        $display("[TB] reset during debounce");
        applyStimulus(4'h0, 2'd0, 1'b0, 4'h0);
        repeat (12) tick();
        applyStimulus(4'h4, 2'd0, 1'b0, 4'h0);
        repeat (4) tick();
        asyncReset();
        repeat (6) tick();
        checkOutput("postRstEdge6", rdArr[1], 4'h0);
        tick();
        checkOutput("postRstEdge7", rdArr[1], 4'h4);

        $display("[TB] randomized traffic");
        applyStimulus(4'h4, 2'd2, 1'b1, 4'hF);
        tick();
        for (int n = 0; n < 400; n++) begin
            int op;
            if ($urandom_range(0, 3) == 0) inPort = 4'($urandom);
            op         = int'($urandom_range(0, 7));
            address    = 2'($urandom);
            writedata  = 4'($urandom);
            chipselect = 1'($urandom);
            writeN     = 1'b1;
            if (op == 0)      begin address = 2'd2; chipselect = 1'b1; writeN = 1'b0; end
            else if (op == 1) begin address = 2'd3; chipselect = 1'b1; writeN = 1'b0; end
            else if (op == 2) begin chipselect = 1'b0; writeN = 1'b0; end
            else if (op == 3) begin address = 2'($urandom_range(0, 1)); chipselect = 1'b1; writeN = 1'b0; end
            tick();
            if (n == 200) asyncReset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule
